// File: rtl/pulse_wave_pkg.sv
// pulse_wave shared types: level enum, reset-default helpers and the
// saturating step used by the optional slew limiter.
package pulse_wave_pkg;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } level_e;

    // Reset duty: half scale of a w-bit phase ramp.
    function automatic logic [31:0] dflt_duty(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Reset amplitude: full (w-1)-bit magnitude of a w-bit signed sample.
    function automatic logic [31:0] dflt_amp(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt.
    function automatic logic signed [31:0] sat_step(
        input logic signed [31:0] cur,
        input logic signed [31:0] tgt,
        input logic signed [31:0] step
    );
        logic signed [31:0] diff;
        diff = tgt - cur;
        if (diff > step) begin
            return cur + step;
        end else if (diff < -step) begin
            return cur - step;
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/pulse_wave_if.sv
// pulse_wave sample/config bundle; slave is the generator, master the
// phase source and control side.
interface pulse_wave_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16
);
    logic               i_valid;
    logic [PHASE_W-1:0] i_addr;
    logic               i_cfg_we;
    logic [PHASE_W-1:0] i_duty;
    logic [DATA_W-2:0]  i_amp;
    logic               o_valid;
    logic [DATA_W-1:0]  o_data;
    logic               o_wrap;
    logic               o_edge;
    logic               o_cfg_pending;

    modport slave (
        input  i_valid, i_addr, i_cfg_we, i_duty, i_amp,
        output o_valid, o_data, o_wrap, o_edge, o_cfg_pending
    );

    modport master (
        output i_valid, i_addr, i_cfg_we, i_duty, i_amp,
        input  o_valid, o_data, o_wrap, o_edge, o_cfg_pending
    );
endinterface

// File: rtl/pulse_wave_slew.sv
// Target-tracking slew limiter: one bounded step toward the target per
// valid sample, starting from zero after reset.
module pulse_wave_slew
    import pulse_wave_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SLEW_STEP = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_target,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] cur_d;

    always_comb begin
        cur_d = cur_q;
        if (i_valid) begin
            cur_d = DATA_W'(sat_step(32'(signed'(cur_q)),
                                     32'(signed'(i_target)),
                                     32'(SLEW_STEP)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign o_data = cur_q;

endmodule

// File: rtl/pulse_wave.sv
// Pulse/square oscillator with double-buffered duty/amplitude applied at
// phase wrap. Optional output slew limiting under PULSE_WAVE_SLEW_EN.
module pulse_wave
    import pulse_wave_pkg::*;
#(
    parameter int PHASE_W   = 16,
    parameter int DATA_W    = 16,
    parameter int SLEW_STEP = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    pulse_wave_if.slave bus
);

    localparam logic [31:0]        DUTY_RST32 = dflt_duty(PHASE_W);
    localparam logic [31:0]        AMP_RST32  = dflt_amp(DATA_W);
    localparam logic [PHASE_W-1:0] DUTY_RST   = DUTY_RST32[PHASE_W-1:0];
    localparam logic [DATA_W-2:0]  AMP_RST    = AMP_RST32[DATA_W-2:0];

    logic [PHASE_W-1:0] duty_q, duty_d;
    logic [DATA_W-2:0]  amp_q, amp_d;
    logic [PHASE_W-1:0] pduty_q, pduty_d;
    logic [DATA_W-2:0]  pamp_q, pamp_d;
    logic               pend_q, pend_d;
    logic [PHASE_W-1:0] prev_q, prev_d;
    logic               started_q, started_d;
    level_e             lvl_q, lvl_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               edge_q, edge_d;

    logic               wrap_c;
    logic               apply_c;
    logic [PHASE_W-1:0] duty_use;
    logic [DATA_W-2:0]  amp_use;
    level_e             lvl_c;
    logic [DATA_W-1:0]  mag;
    logic [DATA_W-1:0]  target;

    // Pending config lands on the very wrap sample that consumes it.
    always_comb begin
        wrap_c   = !started_q || (bus.i_addr < prev_q);
        apply_c  = bus.i_valid && wrap_c && pend_q;
        duty_use = apply_c ? pduty_q : duty_q;
        amp_use  = apply_c ? pamp_q : amp_q;
        lvl_c    = (bus.i_addr < duty_use) ? LVL_LOW : LVL_HIGH;
        mag      = {1'b0, amp_use};
        target   = (lvl_c == LVL_LOW) ? -mag : mag;
    end

    always_comb begin
        duty_d    = duty_q;
        amp_d     = amp_q;
        pduty_d   = pduty_q;
        pamp_d    = pamp_q;
        pend_d    = pend_q;
        prev_d    = prev_q;
        started_d = started_q;
        lvl_d     = lvl_q;
        valid_d   = bus.i_valid;
        wrap_d    = wrap_q;
        edge_d    = edge_q;
        if (bus.i_valid) begin
            prev_d    = bus.i_addr;
            started_d = 1'b1;
            lvl_d     = lvl_c;
            wrap_d    = wrap_c;
            edge_d    = started_q && (lvl_c != lvl_q);
        end
        if (apply_c) begin
            duty_d = pduty_q;
            amp_d  = pamp_q;
            pend_d = 1'b0;
        end
        // A write racing the wrap stays queued for the next one.
        if (bus.i_cfg_we) begin
            pduty_d = bus.i_duty;
            pamp_d  = bus.i_amp;
            pend_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            duty_q    <= DUTY_RST;
            amp_q     <= AMP_RST;
            pduty_q   <= DUTY_RST;
            pamp_q    <= AMP_RST;
            pend_q    <= 1'b0;
            prev_q    <= '0;
            started_q <= 1'b0;
            lvl_q     <= LVL_LOW;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            amp_q     <= amp_d;
            pduty_q   <= pduty_d;
            pamp_q    <= pamp_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            started_q <= started_d;
            lvl_q     <= lvl_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            edge_q    <= edge_d;
        end
    end

`ifdef PULSE_WAVE_SLEW_EN
    pulse_wave_slew #(
        .DATA_W    (DATA_W),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (bus.i_valid),
        .i_target (target),
        .o_data   (bus.o_data)
    );
`else
    logic [DATA_W-1:0] data_q, data_d;
    logic              unused_slew;

    assign unused_slew = |SLEW_STEP;

    always_comb begin
        data_d = data_q;
        if (bus.i_valid) begin
            data_d = target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.o_data = data_q;
`endif

    assign bus.o_valid       = valid_q;
    assign bus.o_wrap        = wrap_q;
    assign bus.o_edge        = edge_q;
    assign bus.o_cfg_pending = pend_q;

endmodule

// File: tb/tb_pulse_wave.sv
// Directed bench for pulse_wave: ramp levels, double-buffered config,
// wrap/edge strobes, valid gaps and mid-run reset (default build).
module tb_pulse_wave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pulse_wave_if #(.PHASE_W(16), .DATA_W(16)) bus ();

    pulse_wave #(
        .PHASE_W   (16),
        .DATA_W    (16),
        .SLEW_STEP (1024)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One valid sample, then check all outputs one edge later.
    task automatic smp(input logic [15:0] a, input bit we,
                       input logic [15:0] d, input logic [14:0] am,
                       input logic [15:0] ed, input bit ew,
                       input bit ee, input bit ep);
        bus.i_valid  = 1'b1;
        bus.i_addr   = a;
        bus.i_cfg_we = we;
        bus.i_duty   = d;
        bus.i_amp    = am;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_cfg_we = 1'b0;
        chk($sformatf("valid@%h", a), {31'd0, bus.o_valid}, 32'd1);
        chk($sformatf("data@%h", a), {16'd0, bus.o_data}, {16'd0, ed});
        chk($sformatf("wrap@%h", a), {31'd0, bus.o_wrap}, {31'd0, ew});
        chk($sformatf("edge@%h", a), {31'd0, bus.o_edge}, {31'd0, ee});
        chk($sformatf("pend@%h", a), {31'd0, bus.o_cfg_pending},
            {31'd0, ep});
    endtask

    // Idle cycle (optionally with a config write); outputs must hold.
    task automatic idle(input bit we, input logic [15:0] d,
                        input logic [14:0] am, input logic [15:0] ed,
                        input bit ep);
        bus.i_valid  = 1'b0;
        bus.i_cfg_we = we;
        bus.i_duty   = d;
        bus.i_amp    = am;
        @(posedge clk);
        #1;
        bus.i_cfg_we = 1'b0;
        chk("gap_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("gap_data", {16'd0, bus.o_data}, {16'd0, ed});
        chk("gap_pend", {31'd0, bus.o_cfg_pending}, {31'd0, ep});
    endtask

    task automatic rst_chk();
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_data", {16'd0, bus.o_data}, 32'd0);
        chk("rst_wrap", {31'd0, bus.o_wrap}, 32'd0);
        chk("rst_edge", {31'd0, bus.o_edge}, 32'd0);
        chk("rst_pend", {31'd0, bus.o_cfg_pending}, 32'd0);
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_addr   = '0;
        bus.i_cfg_we = 1'b0;
        bus.i_duty   = '0;
        bus.i_amp    = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_chk();
        rst_n = 1'b1;

        // Period 1: legacy square at defaults.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            a = 16'(i * 16'h1000);
            smp(a, 1'b0, 16'h0, 15'h0,
                (i < 8) ? 16'h8001 : 16'h7FFF, i == 0, i == 8, 1'b0);
        end

        // Period 2: write mid-period, old levels persist.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            a = 16'(i * 16'h1000);
            smp(a, i == 6, 16'h4000, 15'h1000,
                (i < 8) ? 16'h8001 : 16'h7FFF, i == 0,
                (i == 0) || (i == 8), i >= 6);
        end

        // Period 3: new duty/amp applied at wrap.
        smp(16'h0000, 0, 0, 0, 16'hF000, 1, 1, 0);
        smp(16'h2000, 0, 0, 0, 16'hF000, 0, 0, 0);
        smp(16'h4000, 0, 0, 0, 16'h1000, 0, 1, 0);
        smp(16'hC000, 0, 0, 0, 16'h1000, 0, 0, 0);

        // Write A, then write B coincident with the wrap.
        smp(16'hE000, 1, 16'h0000, 15'h0800, 16'h1000, 0, 0, 1);
        smp(16'h1000, 1, 16'h8000, 15'h0200, 16'h0800, 1, 0, 1);
        smp(16'h3000, 0, 0, 0, 16'h0800, 0, 0, 1);
        smp(16'h9000, 0, 0, 0, 16'h0800, 0, 0, 1);
        smp(16'hFFFF, 0, 0, 0, 16'h0800, 0, 0, 1);
        smp(16'hFFFF, 0, 0, 0, 16'h0800, 0, 0, 1);
        smp(16'h0000, 0, 0, 0, 16'hFE00, 1, 1, 0);
        smp(16'h8000, 0, 0, 0, 16'h0200, 0, 1, 0);

        // Valid gap with an amp=0 write inside it.
        idle(0, 0, 0, 16'h0200, 0);
        idle(1, 16'h8000, 15'h0000, 16'h0200, 1);
        smp(16'h1000, 0, 0, 0, 16'h0000, 1, 1, 0);
        smp(16'h9000, 0, 0, 0, 16'h0000, 0, 1, 0);

        // Reset with a pending write discards it.
        smp(16'hA000, 1, 16'h0000, 15'h0100, 16'h0000, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_chk();
        rst_n = 1'b1;
        smp(16'h3000, 0, 0, 0, 16'h8001, 1, 0, 0);
        smp(16'hB000, 0, 0, 0, 16'h7FFF, 0, 1, 0);
        smp(16'h2000, 0, 0, 0, 16'h8001, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_wave.md
Name: pulse_wave

Overview:
- Parametrised pulse/square-wave generator driven by a phase ramp from the shared phase accumulator.
- Successor to the fixed 50%-duty, fixed-amplitude square generator: adds programmable duty and amplitude, double-buffered so updates only apply at phase wrap, plus a valid handshake and wrap/edge strobes.
- Sits alongside the other oscillator shapes feeding the voice mixer.

Parameters:
- PHASE_W, 16, width of phase input and duty threshold.
- DATA_W, 16, width of signed output sample.
- SLEW_STEP, 1024, maximum output change per valid sample. Used only when PULSE_WAVE_SLEW_EN is defined.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  phase sample valid.
- i_addr  in  PHASE_W  phase ramp, unsigned.
- i_cfg_we  in  1  write strobe for the pending duty/amplitude registers.
- i_duty  in  PHASE_W  threshold: phase < duty gives the low level.
- i_amp  in  DATA_W-1  unsigned amplitude magnitude.
- o_valid  out  1  output sample valid.
- o_data  out  DATA_W  signed sample, two's complement.
- o_wrap  out  1  sample was the first of a new period.
- o_edge  out  1  output level changed on this sample.
- o_cfg_pending  out  1  pending config not yet applied.

Behaviour:
- Reset (i_rst_n=0 at posedge) values:
  - o_valid=0, o_data=0, o_wrap=0, o_edge=0, o_cfg_pending=0.
  - Active duty = 1<<(PHASE_W-1); active amp = all ones (0x7FFF at defaults).
  - prev_phase=0, started=0, last level=low.
- Latency: one cycle. A sample accepted on i_valid at edge N gives o_valid=1 with o_data/o_wrap/o_edge after edge N. The outputs hold their values while o_valid=0. No backpressure.
- Level selection: phase < active duty gives -amp; otherwise +amp.
  - Defaults reproduce the legacy square: -32767 for MSB=0, +32767 for MSB=1.
  - amp=0 gives 0 at both levels.
  - duty=0 gives a constant high level.
  - duty=2^PHASE_W-1 is high only at the maximum phase; a constant low level is not reachable, by design.
- Wrap detection:
  - A valid sample with started=1 and i_addr < prev_phase is a wrap.
  - The first valid sample after reset is treated as a wrap.
  - prev_phase updates on every valid sample.
  - Equal consecutive phases are not a wrap.
- Double buffering:
  - i_cfg_we loads the pending duty/amp and sets o_cfg_pending on the next cycle.
  - On a wrap sample, if pending was set before this cycle, the pending values become active and are used for that same sample; pending then clears.
  - i_cfg_we coincident with a wrap: the wrap consumes the older pending value, if any. The new write stays pending for the next wrap, and pending remains set.
  - Repeated writes before a wrap: last write wins.
- o_edge = valid sample whose level (high/low) differs from the previous valid sample's level. It is not asserted on the first sample after reset.
- Reset mid-operation: all state returns to reset values and pending config is discarded.

Optional Feature:
- Macro: PULSE_WAVE_SLEW_EN.
- Defined:
  - o_data moves toward the target (±amp) by at most SLEW_STEP per valid sample, clamping exactly at the target with no overshoot.
  - The slew starts from 0 after reset.
  - o_edge still follows the target level, not o_data.
- Undefined: o_data equals the target immediately and SLEW_STEP is ignored.

Decomposition:
- Package pulse_wave_pkg:
  - default duty and amp constants as functions of PHASE_W/DATA_W;
  - the level enum (LVL_LOW, LVL_HIGH);
  - a saturating signed-step helper function.
- One sub-module, pulse_wave_slew: target-tracking slew limiter, instantiated only under PULSE_WAVE_SLEW_EN.

Test Plan:
- Reset, then ramp 0x0000→0xFFFF step 0x1000 with defaults:
  - o_data=0x8001 for phases below 0x8000 and 0x7FFF from 0x8000;
  - o_edge at 0x8000;
  - o_wrap on the first sample.
- Write duty=0x4000, amp=0x1000 mid-period (phase 0x6000):
  - the old levels persist until the phase wraps 0xF000→0x0000;
  - then o_data=0xF000 below 0x4000 and 0x1000 above;
  - o_cfg_pending clears after the wrap.
- i_cfg_we coincident with a wrap sample: the earlier pending value applies, the new value applies at the next wrap, and o_cfg_pending stays 1 between them.
- Edge cases:
  - duty=0 gives constant +amp with no o_edge;
  - amp=0 gives o_data=0;
  - i_valid gaps give no o_valid, and o_data is held.
- Assert i_rst_n=0 mid-period with a pending write: the next samples use defaults and o_cfg_pending=0.
- With PULSE_WAVE_SLEW_EN and SLEW_STEP=1024, amp=0x0C00, low→high transition: o_data sequence is -3072, -2048, -1024, 0, 1024, 2048, 3072, then holds.
